hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS pipeline. It watches the IF/ID, ID/EX and EX/MEM stage contents and drives the stall and flush inputs of the PC, IF/ID and ID/EX registers. It handles load-use bubbles, control-flow redirects and, optionally, multi-cycle multiply/divide occupancy of EX. Stall/flush cycles are counted for performance analysis.

## Interface
- MDU_LAT, 32: total cycles a multiply/divide occupies EX (≥2).
- CNT_W, 32: width of each performance counter.

- clk  in  1  pipeline clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- IFIDRs / IFIDRt  in  5 each  source register fields of the instruction in ID.
- IFIDUsesRs / IFIDUsesRt  in  1 each  ID instruction actually reads that source.
- IDEXMemRead  in  1  instruction in EX is a load.
- IDEXRegRd  in  5  write-back destination of the instruction in EX.
- ExRedirect  in  1  EX resolved a taken branch/jump (NPCType ≠ sequential).
- MduStart  in  1  EX instruction is mult/div; pulse valid in the first EX cycle only.
- PCStall  out  1  hold PC.
- IFIDStall / IFIDFlush  out  1 each  hold / clear IF/ID.
- IDEXStall / IDEXFlush  out  1 each  hold / clear ID/EX.
- MduBusy  out  1  multi-cycle operation in progress.
- StallCycles  out  CNT_W  cycles with PCStall=1.
- FlushCount  out  CNT_W  cycles with IFIDFlush or IDEXFlush =1.

## Operation
- FSM states: RUN, MDU_BUSY, MDU_LAST.
- Stall and flush outputs are combinational from state and inputs, so they act in the same cycle. Counters and FSM are registered.
- RUN priority (highest first):
  1. ExRedirect: IFIDFlush=1, IDEXFlush=1; no stall. MduStart in the same cycle is ignored.
  2. MduStart (MDU_EN only): PCStall=IFIDStall=IDEXStall=1. Load counter with MDU_LAT−2, go to MDU_BUSY. If MDU_LAT=2, go straight to MDU_LAST.
  3. Load-use: IDEXMemRead=1, IDEXRegRd≠0, and (IFIDUsesRs and IFIDRs==IDEXRegRd, or IFIDUsesRt and IFIDRt==IDEXRegRd). Response: PCStall=1, IFIDStall=1, IDEXFlush=1 (bubble). Single cycle; the condition clears next cycle naturally.
  4. Otherwise all stall/flush outputs are 0.
- MDU_BUSY: PCStall=IFIDStall=IDEXStall=1. The counter decrements each cycle; at 0, go to MDU_LAST. ExRedirect, MduStart and load-use are ignored.
- MDU_LAST: all outputs 0 so the pipe advances. Next state is RUN. Load-use detection is re-evaluated in RUN on the following instruction.
- MduBusy=1 in MDU_BUSY and in the entry cycle of RUN→MDU_BUSY.
- StallCycles increments when PCStall=1. FlushCount increments when either flush=1. Both wrap modulo 2^CNT_W.

## Timing
- Reset (rst=0, asynchronous):
  - state=RUN, MDU counter=0, StallCycles=0, FlushCount=0, MduBusy=0.
  - All stall/flush outputs forced to 0 while rst=0, regardless of inputs.
- Load-use latency: exactly 1 bubble cycle.
- Redirect cost: 2 flushed slots, asserted in the resolve cycle.
- MDU: EX is held for exactly MDU_LAT cycles (entry cycle + MDU_LAT−2 busy cycles + MDU_LAST), counted from the MduStart cycle.
- Reset asserted mid-MDU: the operation is abandoned and the stalls drop immediately.
- IDEXRegRd=0 never causes a stall.

## Configuration
- HAZARD_MDU_EN defined: MDU_BUSY/MDU_LAST states, the counter and MduBusy are present.
- Not defined:
  - MduStart is ignored.
  - The FSM reduces to RUN.
  - MduBusy is tied to 0.
  - MDU_LAT is unused.

## Structure
- hazard_pkg holds:
  - state encoding localparams (RUN=2'd0, MDU_BUSY=2'd1, MDU_LAST=2'd2);
  - the default MDU_LAT;
  - the register-zero constant.
- One sub-module, hazard_perf_cnt: a CNT_W wrapping counter with increment enable and async active-low reset. It is instantiated twice.

## Test plan
- Reset mid-run: rst low for 3 cycles during MDU_BUSY → all outputs 0, StallCycles=0, state RUN after release.
- Load-use: IDEXMemRead=1, IDEXRegRd=8, IFIDRs=8, IFIDUsesRs=1 → one cycle of PCStall=IFIDStall=IDEXFlush=1, StallCycles=1. The same case with IDEXRegRd=0 → no stall.
- Redirect with coincident load-use: ExRedirect=1 plus a matching load-use → IFIDFlush=IDEXFlush=1, PCStall=0, FlushCount +1.
- MDU, MDU_LAT=32: MduStart pulse → PCStall high for 31 consecutive cycles, low on the 32nd; StallCycles=31.
- MDU plus redirect: ExRedirect pulsed during MDU_BUSY → ignored; FlushCount unchanged.
- Macro off: MduStart=1 → no stall; MduBusy stays 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller: FSM encoding, default
// multiply/divide latency and the hard-wired zero register index.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_LAST = 2'd2
  } state_e;

  localparam int         MDU_LAT_DEFAULT = 32;
  localparam logic [4:0] REG_ZERO        = 5'd0;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Free-running wrapping event counter used for stall/flush statistics.
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage pipeline: load-use bubbles, redirect
// flushes and (with HAZARD_MDU_EN defined) multi-cycle mult/div occupancy of EX.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MDU_LAT = MDU_LAT_DEFAULT,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IFIDRs,
  input  logic [4:0]       IFIDRt,
  input  logic             IFIDUsesRs,
  input  logic             IFIDUsesRt,
  input  logic             IDEXMemRead,
  input  logic [4:0]       IDEXRegRd,
  input  logic             ExRedirect,
  input  logic             MduStart,
  output logic             PCStall,
  output logic             IFIDStall,
  output logic             IFIDFlush,
  output logic             IDEXStall,
  output logic             IDEXFlush,
  output logic             MduBusy,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
);

  logic load_use;

  assign load_use = IDEXMemRead && (IDEXRegRd != REG_ZERO) &&
                    ((IFIDUsesRs && (IFIDRs == IDEXRegRd)) ||
                     (IFIDUsesRt && (IFIDRt == IDEXRegRd)));

`ifdef HAZARD_MDU_EN
  // Counter holds the remaining busy cycles after the entry cycle.
  localparam int             MCW      = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;
  localparam logic [MCW-1:0] MDU_LOAD = MCW'(MDU_LAT - 2);

  state_e         state_q, state_d;
  logic [MCW-1:0] mcnt_q, mcnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mcnt_q  <= mcnt_d;
    end
  end
`else
  logic unused_mdu;
  assign unused_mdu = MduStart ^ (MDU_LAT != 0);
`endif

  always_comb begin
    PCStall   = 1'b0;
    IFIDStall = 1'b0;
    IFIDFlush = 1'b0;
    IDEXStall = 1'b0;
    IDEXFlush = 1'b0;
    MduBusy   = 1'b0;
`ifdef HAZARD_MDU_EN
    state_d   = state_q;
    mcnt_d    = mcnt_q;
    case (state_q)
      RUN: begin
`endif
        if (ExRedirect) begin
          IFIDFlush = 1'b1;
          IDEXFlush = 1'b1;
        end
`ifdef HAZARD_MDU_EN
        else if (MduStart) begin
          PCStall   = 1'b1;
          IFIDStall = 1'b1;
          IDEXStall = 1'b1;
          MduBusy   = 1'b1;
          mcnt_d    = MDU_LOAD;
          state_d   = (MDU_LAT <= 2) ? MDU_LAST : MDU_BUSY;
        end
`endif
        else if (load_use) begin
          PCStall   = 1'b1;
          IFIDStall = 1'b1;
          IDEXFlush = 1'b1;
        end
`ifdef HAZARD_MDU_EN
      end
      MDU_BUSY: begin
        PCStall   = 1'b1;
        IFIDStall = 1'b1;
        IDEXStall = 1'b1;
        MduBusy   = 1'b1;
        mcnt_d    = mcnt_q - MCW'(1);
        if (mcnt_q <= MCW'(1)) begin
          state_d = MDU_LAST;
        end
      end
      MDU_LAST: state_d = RUN;
      default:  state_d = RUN;
    endcase
`endif
    // Reset overrides everything so an abandoned operation releases the pipe at once.
    if (!rst) begin
      PCStall   = 1'b0;
      IFIDStall = 1'b0;
      IFIDFlush = 1'b0;
      IDEXStall = 1'b0;
      IDEXFlush = 1'b0;
      MduBusy   = 1'b0;
    end
  end

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .en_i (PCStall),
    .cnt_o(StallCycles)
  );

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk  (clk),
    .rst  (rst),
    .en_i (IFIDFlush | IDEXFlush),
    .cnt_o(FlushCount)
  );

endmodule
